// File: rtl/tdr_pulse_timer_if.sv
// Handshake/bus bundle between the TDR pulse timer, the line model and the result consumer.
interface tdr_pulse_timer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             rx_signal;
  logic             tx_pulse;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] tof;
  logic             timeout;

  modport master (
    output start, rx_signal, result_ready,
    input  tx_pulse, busy, result_valid, tof, timeout
  );

  modport slave (
    input  start, rx_signal, result_ready,
    output tx_pulse, busy, result_valid, tof, timeout
  );
endinterface

// File: rtl/tdr_pulse_timer.sv
// TDR launch + time-of-flight counter: fires a pulse, counts cycles to the first
// qualified rising edge of the return (or timeout), then offers the result on valid/ready.
module tdr_pulse_timer #(
  parameter int CNT_W       = 16,
  parameter int PULSE_WIDTH = 4,
  parameter int BLANK       = 0,
  parameter int MAX_COUNT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  tdr_pulse_timer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_LISTEN, S_RESULT} state_t;

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_count, w_count_n;
  logic [CNT_W-1:0] r_tof, w_tof_n;
  logic             r_rx_prev, r_tx, w_tx_n, r_timeout, w_timeout_n;
  logic             w_edge, w_blank_ok;

  assign w_edge = bus.rx_signal & ~r_rx_prev;

  // A zero blanking window would make the compare constant, so drop it entirely.
  if (BLANK == 0) begin : g_noblank
    assign w_blank_ok = 1'b1;
  end else begin : g_blank
    assign w_blank_ok = (r_count >= CNT_W'(BLANK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_rx_prev <= 1'b0;
      r_tx      <= 1'b0;
      r_tof     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_count   <= w_count_n;
      r_rx_prev <= bus.rx_signal;
      r_tx      <= w_tx_n;
      r_tof     <= w_tof_n;
      r_timeout <= w_timeout_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_count_n   = r_count;
    w_tx_n      = r_tx;
    w_tof_n     = r_tof;
    w_timeout_n = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_n = S_FIRE;
          w_count_n = '0;
          w_tx_n    = 1'b1;
        end
      end
      S_FIRE, S_LISTEN: begin
        // Detection wins over timeout; either one ends the launch pulse early.
        if (w_edge && w_blank_ok) begin
          w_state_n   = S_RESULT;
          w_tof_n     = r_count;
          w_timeout_n = 1'b0;
          w_tx_n      = 1'b0;
        end else if (r_count == MAX_C) begin
          w_state_n   = S_RESULT;
          w_tof_n     = MAX_C;
          w_timeout_n = 1'b1;
          w_tx_n      = 1'b0;
        end else begin
          w_count_n = r_count + 1'b1;
          if (r_state == S_FIRE && r_count == PW_LAST) begin
            w_state_n = S_LISTEN;
            w_tx_n    = 1'b0;
          end
        end
      end
      S_RESULT: begin
        if (bus.result_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign bus.tx_pulse     = r_tx;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result_valid = (r_state == S_RESULT);
  assign bus.tof          = r_tof;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_tdr_pulse_timer.sv
// Scoreboard bench: the driver pushes expected results from a waveform-level model,
// the monitor pops and compares whenever the timer presents a result.
module tb_tdr_pulse_timer;
  localparam int CNT_W = 16;
  localparam int PW    = 6;
  localparam int BLANK = 3;
  localparam int MAXC  = 100;

  typedef struct {
    int tof;
    bit to;
    int width;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdr_pulse_timer_if #(.CNT_W(CNT_W)) bus();

  tdr_pulse_timer #(
    .CNT_W(CNT_W), .PULSE_WIDTH(PW), .BLANK(BLANK), .MAX_COUNT(MAXC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Loopback shift line with a selectable tap standing in for the transmission line.
  logic [127:0] line = '0;
  logic         loop_en = 1'b0;
  int           tap_d = 64;
  logic         drv_rx = 1'b0;
  always @(posedge clk) line <= {line[126:0], bus.tx_pulse};
  assign bus.rx_signal = loop_en ? line[tap_d-1] : drv_rx;

  int   checks = 0;
  int   passes = 0;
  exp_t sbq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // First qualified rising edge of the return waveform, else timeout at MAXC.
  function automatic void ref_model(input bit pre, input bit lv[128], output int tof, output bit to);
    bit prev;
    prev = pre;
    tof  = MAXC;
    to   = 1'b1;
    for (int k = 0; k <= MAXC; k++) begin
      if (lv[k] && !prev && k >= BLANK) begin
        tof = k;
        to  = 1'b0;
        return;
      end
      prev = lv[k];
    end
  endfunction

  // Monitor
  initial begin
    bit   pv, seen, ptx;
    int   txc, htof;
    bit   hto;
    exp_t e;
    pv = 0; seen = 0; ptx = 0; txc = 0; htof = 0; hto = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pv = 0; seen = 0; ptx = 0;
        continue;
      end
      if (bus.tx_pulse) txc = ptx ? txc + 1 : 1;
      ptx = bus.tx_pulse;
      if (pv && bus.result_ready) begin
        check("valid_after_handshake", bus.result_valid, 0);
        check("busy_after_handshake", bus.busy, 0);
      end
      if (bus.result_valid && !seen) begin
        seen = 1;
        if (sbq.size() == 0) fail_now("unexpected_result");
        else begin
          e = sbq.pop_front();
          check("tof", bus.tof, e.tof);
          check("timeout", bus.timeout, e.to);
          check("tx_width", txc, e.width);
          check("busy_in_result", bus.busy, 1);
        end
        htof = bus.tof;
        hto  = bus.timeout;
      end else if (bus.result_valid) begin
        check("tof_hold", bus.tof, htof);
        check("timeout_hold", bus.timeout, hto);
      end
      if (!bus.result_valid) seen = 0;
      pv = bus.result_valid;
    end
  end

  task automatic measure(input bit pre, input bit lv[128], input bit loop, input int d,
                         input bit bp, input int abort_at);
    int   n, k, tof;
    bit   to;
    exp_t e;
    n = 0;
    while (bus.busy && n < 300) begin @(negedge clk); n++; end
    if (bus.busy) begin check("idle_wait", 1, 0); return; end
    if (loop) begin
      loop_en = 1'b0;
      repeat (130) @(negedge clk);
    end
    loop_en = loop;
    tap_d   = d;
    drv_rx  = pre;
    repeat (2) @(negedge clk);
    if (abort_at < 0) begin
      if (loop) begin tof = d; to = 1'b0; end
      else ref_model(pre, lv, tof, to);
      e.tof = tof; e.to = to; e.width = (tof + 1 < PW) ? tof + 1 : PW;
      sbq.push_back(e);
    end
    bus.start = 1'b1;
    @(negedge clk);
    k = 0;
    while (!bus.result_valid && k < 200) begin
      if (k == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check("abort_tx", bus.tx_pulse, 0);
        check("abort_valid", bus.result_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_tof", bus.tof, 0);
        check("abort_timeout", bus.timeout, 0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      drv_rx    = lv[k < 128 ? k : 127];
      bus.start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      k++;
    end
    if (!bus.result_valid) begin check("result_wait", 0, 1); bus.start = 1'b0; return; end
    n = 0;
    if (bp) begin
      repeat (10) begin
        bus.result_ready = 1'b0;
        bus.start        = ~bus.start;
        @(negedge clk);
      end
      bus.result_ready = 1'b1;
      bus.start        = 1'b1;
      @(negedge clk);
    end else begin
      while (bus.result_valid && n < 40) begin
        bus.result_ready = (n >= 30) || ($urandom_range(0, 1) == 1);
        bus.start        = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        n++;
      end
    end
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    check("released", bus.result_valid, 0);
  endtask

  initial begin
    bit lv[128];
    int d;
    bit lvl;
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx_pulse, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_tof", bus.tof, 0);
    check("rst_timeout", bus.timeout, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (lv[k]) lv[k] = 1'b0;
    measure(0, lv, 1, 64, 0, -1);                        // loopback
    measure(0, lv, 0, 0, 0, -1);                         // timeout
    foreach (lv[k]) lv[k] = (k == 1) || (k >= 20);       // blanked feed-through
    measure(0, lv, 0, 0, 0, -1);
    foreach (lv[k]) lv[k] = (k >= 3);                    // truncates the pulse
    measure(0, lv, 0, 0, 0, -1);
    foreach (lv[k]) lv[k] = (k >= 2);                    // edge just inside blanking
    measure(0, lv, 0, 0, 0, -1);
    foreach (lv[k]) lv[k] = (k >= MAXC);                 // edge on the timeout count
    measure(0, lv, 0, 0, 0, -1);
    foreach (lv[k]) lv[k] = (k >= 30);
    measure(0, lv, 0, 0, 1, -1);                         // backpressure
    foreach (lv[k]) lv[k] = (k < 30) || (k >= 40);       // high on entry
    measure(1, lv, 0, 0, 0, -1);
    foreach (lv[k]) lv[k] = 1'b0;
    measure(0, lv, 0, 0, 0, 50);                         // async abort
    foreach (lv[k]) lv[k] = (k >= 25);
    measure(0, lv, 0, 0, 0, -1);

    for (int r = 0; r < 24; r++) begin
      lvl = ($urandom_range(0, 1) == 1);
      d   = lvl;
      foreach (lv[k]) begin
        if ($urandom_range(0, 31) == 0) lvl = ~lvl;
        lv[k] = lvl;
      end
      measure(d[0], lv, 0, 0, ($urandom_range(0, 3) == 0), -1);
    end
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(PW, 90);
      measure(0, lv, 1, d, ($urandom_range(0, 1) == 1), -1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tdr_pulse_timer.md
Name: tdr_pulse_timer

Overview:
- TDR launch and time-of-flight stage wrapped around the transmission-line model.
- On a start request it drives a launch pulse into the line input (tx_pulse -> delay line in_signal).
- It then watches the line output (delay line out_signal -> rx_signal) and counts cycles until the first qualified rising edge of the reflection, or until timeout.
- The result (tof, timeout flag) is presented on a valid/ready handshake to the downstream feature/ML capture logic.

Parameters:
- CNT_W, 16, width of the cycle counter and of the tof output.
- PULSE_WIDTH, 4, launch pulse length in cycles; legal range 1..MAX_COUNT.
- BLANK, 0, rx edges seen while count < BLANK are ignored (feed-through rejection).
- MAX_COUNT, 1023, timeout count; must be < 2^CNT_W and >= PULSE_WIDTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- start  in  1  measurement request; sampled only in IDLE.
- rx_signal  in  1  line return; connects to the delay line output.
- tx_pulse  out  1  launch pulse, registered; connects to the delay line input.
- busy  out  1  high whenever state != IDLE.
- result_valid  out  1  tof/timeout are valid.
- result_ready  in  1  consumer accepts the result.
- tof  out  CNT_W  count value at the detected edge, or MAX_COUNT on timeout.
- timeout  out  1  high when the result is a timeout (no qualified edge seen).

Behaviour:
- States: IDLE, FIRE, LISTEN, RESULT. All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- Reset, asynchronous: state=IDLE, count=0, rx_prev=0, tx_pulse=0, busy=0, result_valid=0, tof=0, timeout=0.
- rx_prev <= rx_signal every cycle, in all states. edge = rx_signal & ~rx_prev. A level that is already high on entry is not an edge; it must fall and rise again.
- IDLE:
  - start=1 at edge E0 -> FIRE, count<=0, tx_pulse<=1.
  - start=0 -> remain in IDLE.
- FIRE and LISTEN:
  - count increments by 1 each edge; the value during the cycle after E0 is 0.
  - Detection is evaluated every cycle in either state: edge && count>=BLANK -> tof<=count, timeout<=0, tx_pulse<=0, go to RESULT. In FIRE this truncates the pulse.
  - Else if count==MAX_COUNT -> tof<=MAX_COUNT, timeout<=1, tx_pulse<=0, go to RESULT.
  - Detection has priority over timeout in the same cycle.
  - Else in FIRE with count==PULSE_WIDTH-1 -> tx_pulse<=0, go to LISTEN. tx_pulse is therefore high for exactly PULSE_WIDTH cycles (counts 0..PULSE_WIDTH-1).
- Latency: a pulse launched into a DELAY-stage shift line returns in the cycle where count==DELAY, giving tof=DELAY.
- RESULT:
  - result_valid=1; tof and timeout are held stable.
  - On an edge with result_valid&&result_ready -> IDLE; result_valid drops in the next cycle.
  - start is ignored in RESULT, including in the handshake cycle. The earliest new acceptance is the cycle after return to IDLE.
  - tof and timeout keep their last values in IDLE and are meaningful only while result_valid=1.
- The count never exceeds MAX_COUNT and never wraps.
- start while busy is dropped, not queued.
- Async reset mid-operation aborts the measurement. tx_pulse and result_valid go low immediately, and no partial result is produced.

Test Plan:
- Loopback through a 64-stage delay line, defaults, start one cycle -> tx_pulse high exactly 4 cycles; result_valid with tof=64, timeout=0; busy low the cycle after handshake.
- rx_signal tied 0, MAX_COUNT=100 -> result in the cycle after count reaches 100; tof=100, timeout=1; tx_pulse was high 4 cycles.
- BLANK=8, rx rises at count 3, falls at count 5, rises again at count 20 -> tof=20, timeout=0.
- PULSE_WIDTH=4, BLANK=0, rx rises at count 2 -> tx_pulse deasserts after 3 cycles high; tof=2.
- Backpressure: result_ready=0 for 10 cycles with start pulsed during RESULT -> tof/timeout/result_valid stable and no restart. Then ready=1 for 1 cycle -> IDLE; a start 2 cycles later is accepted.
- rx_signal held 1 from IDLE through launch, dropped at count 30, raised at count 40 -> tof=40. Separately, async rst asserted at count 50 in LISTEN -> all outputs 0 immediately; the next start gives a normal tof.
